// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one req/gnt/rvalid memory port.
// Tracks response ownership in an in-order owner FIFO and routes rvalid back.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvld_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        proto_err_o
);

  localparam logic [1:0] ARB    = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [2:0] FIFO_DEPTH = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] PTR_LAST   = 2'(MAX_OUTSTANDING - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [2:0] count_q, count_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] owner_q, owner_d;
  logic       proto_err_q, proto_err_d;

  logic sel_valid, sel_data;
  logic fifo_empty, fifo_full;
  logic push, pop, spurious, mem_req, head_owner;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 1'b0;
    case (state_q)
      LOCK_I: sel_valid = 1'b1;
      LOCK_D: begin
        sel_valid = 1'b1;
        sel_data  = 1'b1;
      end
      default: begin
        if (data_req_i && !(starve_q == STARVE_MAX && instr_req_i)) begin
          sel_valid = 1'b1;
          sel_data  = 1'b1;
        end else if (instr_req_i) begin
          sel_valid = 1'b1;
        end
      end
    endcase
  end

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == FIFO_DEPTH);
  // count is held at zero during reset, so pop and the rvalid routing are quiet then too
  assign pop        = mem_rvalid_i & ~fifo_empty;
  assign spurious   = mem_rvalid_i & fifo_empty;
  assign mem_req    = rst_ni & sel_valid & (~fifo_full | pop);
  assign push       = mem_req & mem_gnt_i;
  assign head_owner = owner_q[rd_ptr_q];

  assign mem_req_o   = mem_req;
  assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = sel_data & data_we_i;
  assign mem_be_o    = sel_data ? data_be_i    : 4'hF;
  assign mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

  assign instr_gnt_o   = push & ~sel_data;
  assign data_gnt_o    = push & sel_data;
  assign instr_rvld_o  = pop & ~head_owner;
  assign data_rvalid_o = pop & head_owner;
  assign instr_err_o   = instr_rvld_o & mem_err_i;
  assign data_err_o    = data_rvalid_o & mem_err_i;
  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign proto_err_o   = proto_err_q;

  always_comb begin
    state_d = state_q;
    if (mem_req) state_d = mem_gnt_i ? ARB : (sel_data ? LOCK_D : LOCK_I);
  end

  always_comb begin
    starve_d = 4'd0;
    if (instr_req_i && !instr_gnt_o)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
  end

  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      owner_d[wr_ptr_q] = sel_data;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? 2'd0 : rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  assign proto_err_d = proto_err_q | spurious;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB;
      starve_q    <= 4'd0;
      count_q     <= 3'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      owner_q     <= 4'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      owner_q     <= owner_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// queue-based model of arbitration, locking, starvation and response ownership.
module tb_mem_port_arbiter;

  localparam int MAX   = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvld_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic        proto_err_o;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAX), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvld_o(instr_rvld_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: in-order owners of outstanding transfers (0=instr, 1=data)
  bit mq[$];
  int lock_sel;
  int starve;
  bit proto;
  int m_sel;
  bit e_req, e_igt, e_dgt, e_irv, e_drv, m_pop, m_spur;
  bit i_pend, d_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    lock_sel = -1;
    starve   = 0;
    proto    = 1'b0;
  endtask

  task automatic idle();
    instr_req_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 4'h0;
    data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
  endtask

  // called #0 after a negedge with inputs driven; compares every output to the model
  task automatic eval();
    #1;
    if (lock_sel >= 0) m_sel = lock_sel;
    else if (data_req_i && !(starve == LIMIT && instr_req_i)) m_sel = 1;
    else if (instr_req_i) m_sel = 0;
    else m_sel = -1;
    m_pop  = mem_rvalid_i && (mq.size() > 0);
    m_spur = mem_rvalid_i && (mq.size() == 0);
    e_req  = (m_sel >= 0) && ((mq.size() < MAX) || m_pop);
    e_igt  = e_req && mem_gnt_i && (m_sel == 0);
    e_dgt  = e_req && mem_gnt_i && (m_sel == 1);
    e_irv  = 0;
    e_drv  = 0;
    if (m_pop) begin
      e_irv = (mq[0] == 1'b0);
      e_drv = (mq[0] == 1'b1);
    end
    chk("mem_req", mem_req_o, e_req);
    if (e_req && m_sel == 1) begin
      chk("mem_addr_d", mem_addr_o, data_addr_i);
      chk("mem_we_d", mem_we_o, data_we_i);
      chk("mem_be_d", mem_be_o, data_be_i);
      chk("mem_wdata_d", mem_wdata_o, data_wdata_i);
    end else if (e_req) begin
      chk("mem_addr_i", mem_addr_o, instr_addr_i);
      chk("mem_we_i", mem_we_o, 0);
      chk("mem_be_i", mem_be_o, 4'hF);
      chk("mem_wdata_i", mem_wdata_o, 0);
    end
    chk("instr_gnt", instr_gnt_o, e_igt);
    chk("data_gnt", data_gnt_o, e_dgt);
    chk("instr_rvld", instr_rvld_o, e_irv);
    chk("data_rvalid", data_rvalid_o, e_drv);
    chk("instr_err", instr_err_o, e_irv && mem_err_i);
    chk("data_err", data_err_o, e_drv && mem_err_i);
    if (e_irv) chk("instr_rdata", instr_rdata_o, mem_rdata_i);
    if (e_drv) chk("data_rdata", data_rdata_o, mem_rdata_i);
    chk("proto_err", proto_err_o, proto);
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_pop) void'(mq.pop_front());
    if (m_spur) proto = 1'b1;
    if (e_req && mem_gnt_i) mq.push_back(m_sel[0]);
    if (e_req && !mem_gnt_i) lock_sel = m_sel;
    else if (e_req) lock_sel = -1;
    if (instr_req_i && !e_igt) starve = (starve >= LIMIT) ? LIMIT : starve + 1;
    else starve = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni = 0; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_err_i = 1;
    #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_instr_gnt", instr_gnt_o, 0);
    chk("rst_data_gnt", data_gnt_o, 0);
    chk("rst_instr_rvld", instr_rvld_o, 0);
    chk("rst_data_rvalid", data_rvalid_o, 0);
    chk("rst_errs", {instr_err_o, data_err_o}, 0);
    chk("rst_proto", proto_err_o, 0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_ni = 1;
    model_reset();
    i_pend = 0;
    d_pend = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 0; instr_addr_i = 0; data_addr_i = 0; idle();
    i_pend = 0; d_pend = 0;
    @(negedge clk);
    do_reset();

    // idle after reset, then a response with nothing outstanding
    eval();
    chk("reset_idle_req", mem_req_o, 0);
    advance();
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    eval();
    chk("spur_no_rvld", {instr_rvld_o, data_rvalid_o}, 2'b00);
    advance();
    idle();
    eval();
    chk("proto_set", proto_err_o, 1);
    advance();
    do_reset();
    eval();
    chk("proto_cleared", proto_err_o, 0);
    advance();

    // both request together: data first, each side sees only its own response
    instr_req_i = 1; instr_addr_i = 32'h100; data_req_i = 1; data_addr_i = 32'h2000; mem_gnt_i = 1;
    eval();
    chk("both_addr", mem_addr_o, 32'h2000);
    chk("both_dgnt", data_gnt_o, 1);
    advance();
    data_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11;
    eval();
    chk("both_irvld0", instr_rvld_o, 0);
    chk("both_drvld1", data_rvalid_o, 1);
    chk("both_igt", instr_gnt_o, 1);
    advance();
    instr_req_i = 0; mem_rdata_i = 32'h22;
    eval();
    chk("both_irvld1", instr_rvld_o, 1);
    advance();
    idle(); eval(); advance();

    // starvation: instr wins on its fifth waiting cycle, then data resumes
    for (int c = 0; c < 8; c++) begin
      instr_req_i = (c <= 4); data_req_i = (c <= 5); mem_gnt_i = 1;
      mem_rvalid_i = (c > 0 && c <= 6); mem_rdata_i = 32'(c);
      eval();
      if (c <= 5) begin
        chk("starve_igt", instr_gnt_o, (c == 4));
        chk("starve_dgt", data_gnt_o, (c != 4));
      end
      advance();
    end
    idle();

    // lock on instr while data arrives, write attributes pass through afterwards
    instr_req_i = 1; instr_addr_i = 32'h300;
    eval(); advance();
    data_req_i = 1; data_addr_i = 32'h2000; data_we_i = 1; data_be_i = 4'h3; data_wdata_i = 32'hDEAD_BEEF;
    for (int c = 1; c < 3; c++) begin
      eval();
      chk("lock_addr", mem_addr_o, 32'h300);
      chk("lock_dgt", data_gnt_o, 0);
      advance();
    end
    mem_gnt_i = 1;
    eval();
    chk("lock_igt", instr_gnt_o, 1);
    advance();
    instr_req_i = 0;
    eval();
    chk("after_lock_addr", mem_addr_o, 32'h2000);
    chk("after_lock_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("after_lock_be", mem_be_o, 4'h3);
    advance();
    idle(); mem_rvalid_i = 1;
    eval(); advance();
    eval(); advance();
    idle();

    // I, D grants fill the port; then responses A, B(err), C in order
    mem_gnt_i = 1; instr_req_i = 1; instr_addr_i = 32'h400;
    eval(); advance();
    instr_req_i = 0; data_req_i = 1; data_we_i = 0;
    eval(); advance();
    data_req_i = 0; instr_req_i = 1;
    eval();
    chk("full_req", mem_req_o, 0);
    advance();
    mem_rvalid_i = 1; mem_rdata_i = 32'hA;
    eval();
    chk("pop_push_igt", instr_gnt_o, 1);
    chk("resp_a_rvld", instr_rvld_o, 1);
    chk("resp_a_data", instr_rdata_o, 32'hA);
    advance();
    instr_req_i = 0; mem_rdata_i = 32'hB; mem_err_i = 1;
    eval();
    chk("resp_b_rvld", data_rvalid_o, 1);
    chk("resp_b_data", data_rdata_o, 32'hB);
    chk("resp_b_errs", {instr_err_o, data_err_o}, 2'b01);
    advance();
    mem_rdata_i = 32'hC; mem_err_i = 0;
    eval();
    chk("resp_c_rvld", instr_rvld_o, 1);
    chk("resp_c_data", instr_rdata_o, 32'hC);
    advance();
    idle(); eval(); advance();

    // random traffic with a reset in the middle
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; instr_addr_i = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; data_addr_i = $urandom; data_we_i = 1'($urandom);
        data_be_i = 4'($urandom); data_wdata_i = $urandom;
      end
      instr_req_i  = i_pend;
      data_req_i   = d_pend;
      mem_gnt_i    = ($urandom_range(0, 9) < 7);
      mem_rvalid_i = ((mq.size() > 0) && ($urandom_range(0, 9) < 6)) || ($urandom_range(0, 49) == 0);
      mem_rdata_i  = $urandom;
      mem_err_i    = ($urandom_range(0, 4) == 0);
      eval();
      if (e_igt) begin
        i_pend = 0;
        $display("cycle %0d: instr granted addr=%08h", c, instr_addr_i);
      end
      if (e_dgt) begin
        d_pend = 0;
        $display("cycle %0d: data granted addr=%08h we=%0d", c, data_addr_i, data_we_i);
      end
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted transactions still awaiting rvalid (legal values 1..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles instr may lose arbitration before it is forced to win (legal values 1..15).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports instr_req_i (in, 1), instr_addr_i (in, 32), instr_gnt_o (out, 1), instr_rvld_o (out, 1), instr_rdata_o (out, 32) and instr_err_o (out, 1): the fetch requester, read-only.
REQ-006 SHALL have ports data_req_i (in, 1), data_addr_i (in, 32), data_we_i (in, 1), data_be_i (in, 4), data_wdata_i (in, 32), data_gnt_o (out, 1), data_rvalid_o (out, 1), data_rdata_o (out, 32) and data_err_o (out, 1): the load/store requester.
REQ-007 SHALL have ports mem_req_o (out, 1), mem_addr_o (out, 32), mem_we_o (out, 1), mem_be_o (out, 4), mem_wdata_o (out, 32), mem_gnt_i (in, 1), mem_rvalid_i (in, 1), mem_rdata_i (in, 32) and mem_err_i (in, 1): the single shared memory port.
REQ-008 SHALL have port proto_err_o, out, 1 bit: sticky flag set when a response arrives with nothing outstanding.

Function
REQ-009 SHALL use the req/gnt/rvalid handshake on all ports: a transfer is accepted in the cycle req and gnt are both high; the requester holds req and its attributes stable until then; each accepted transfer produces exactly one rvalid, in order, no earlier than the cycle after gnt.
REQ-010 SHALL implement the state machine ARB, LOCK_I, LOCK_D; reset state is ARB.
REQ-011 In ARB, SHALL select data if data_req_i=1, unless the starvation counter equals STARVE_LIMIT and instr_req_i=1, in which case it SHALL select instr; otherwise it SHALL select instr if instr_req_i=1.
REQ-012 SHALL drive mem_req_o=1 and the selected requester's attributes onto mem_* combinationally when a selection exists and the port is not full; for instr, mem_we_o=0, mem_be_o=4'hF and mem_wdata_o=0.
REQ-013 If mem_req_o=1 and mem_gnt_i=0, SHALL move to LOCK_I or LOCK_D and keep that requester selected until mem_gnt_i=1, then return to ARB; the selection SHALL NOT change while locked.
REQ-014 SHALL drive instr_gnt_o or data_gnt_o as mem_gnt_i ANDed with the selection and mem_req_o; the unselected gnt SHALL be 0.
REQ-015 Starvation counter (4 bit) SHALL increment, saturating at STARVE_LIMIT, in each cycle instr_req_i=1 and instr_gnt_o=0; it SHALL clear on instr_gnt_o=1 or instr_req_i=0.
REQ-016 SHALL keep an owner FIFO of depth MAX_OUTSTANDING: push the owner ID (0=instr, 1=data) on each mem gnt, and pop on mem_rvalid_i.
REQ-017 On pop, SHALL route mem_rvalid_i, mem_rdata_i and mem_err_i to the owner's rvld/rvalid, rdata and err outputs in the same cycle (combinational); the non-owner rvld SHALL be 0, and both rdata outputs MAY carry mem_rdata_i.
REQ-018 Full condition (count==MAX_OUTSTANDING) SHALL force mem_req_o=0 unless mem_rvalid_i=1 in the same cycle (pop frees a slot); a locked selection is retained while full.
REQ-019 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance; pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-020 On mem_rvalid_i=1 with an empty FIFO, SHALL ignore the response (no rvalid to either requester) and set proto_err_o=1 until reset.
REQ-021 When count>0 or a request is locked, a write requester's data, be and we SHALL pass through unchanged; the block SHALL NOT buffer write data.

Reset
REQ-022 While rst_ni=0, SHALL force state=ARB, FIFO count/pointers=0, starvation counter=0 and proto_err_o=0, and drive mem_req_o, instr_gnt_o, data_gnt_o, instr_rvld_o, data_rvalid_o, instr_err_o and data_err_o to 0.
REQ-023 Reset asserted mid-transaction SHALL discard all outstanding owner entries; responses after reset release with an empty FIFO SHALL follow REQ-020.

Verification
REQ-024 Both requesters request in cycle 0 and mem_gnt_i=1 every cycle, with instr_addr_i=0x100 and data_addr_i=0x2000 -> data is granted first with mem_addr_o=0x2000, and instr receives rvld only for its own responses.
REQ-025 data_req_i held high continuously, instr_req_i high, STARVE_LIMIT=4 -> instr_gnt_o=1 no later than the 5th cycle of instr waiting, then data resumes.
REQ-026 instr is selected, mem_gnt_i=0 for 3 cycles, and data_req_i rises in cycle 1 -> mem_addr_o remains the instr address (LOCK_I) until gnt, and data is granted next.
REQ-027 Two grants with no rvalid (MAX_OUTSTANDING=2) -> mem_req_o=0; rvalid arriving together with a pending request -> gnt in the same cycle and count stays 2.
REQ-028 Out-of-order-free mix I, D, I with mem_rdata_i=0xA,0xB,0xC -> instr_rdata_o=0xA, data_rdata_o=0xB, instr_rdata_o=0xC, each with the correct rvalid; mem_err_i=1 on the second response -> data_err_o=1 only.
REQ-029 mem_rvalid_i=1 right after reset -> no requester rvalid and proto_err_o=1; a subsequent reset -> proto_err_o=0.
